// File: rtl/fft_bin_max_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_bin_max_pkg
// Description : Shared DSP-path constants and the FFT bin-max result record.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_bin_max_pkg;

    localparam int c_datlen = 12;
    localparam int c_nfft   = 64;
    localparam int c_bw     = 6;

    // Default LED modulation windows, inclusive bin bounds
    localparam int c_lo730  = 4;
    localparam int c_hi730  = 6;
    localparam int c_lo850  = 10;
    localparam int c_hi850  = 12;

    typedef struct packed {
        logic [c_datlen-1:0] max730;
        logic [c_datlen-1:0] max850;
        logic [c_bw-1:0]     bin730;
        logic [c_bw-1:0]     bin850;
        logic                ovf;
    } result_t;

endpackage : fft_bin_max_pkg
`default_nettype wire

// File: rtl/fft_bin_max_win.sv
`default_nettype none
// ============================================================================
// Module      : win_max_tracker
// Description : Running maximum and its bin index over one inclusive bin window.
// Revision    : 1.0 - initial release
// ============================================================================
module win_max_tracker #(
    parameter int LO     = 4,
    parameter int HI     = 6,
    parameter int DATLEN = 12,
    parameter int BW     = 6
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [BW-1:0]     count,
    input  logic [DATLEN-1:0] in_data,
    input  logic              in_nd,
    output logic [DATLEN-1:0] run_max,
    output logic [BW-1:0]     run_idx
);

    localparam logic [BW-1:0] c_lo   = BW'(LO);
    localparam logic [BW-1:0] c_span = BW'(HI - LO);

    logic [DATLEN-1:0] r_max;
    logic [BW-1:0]     r_idx;
    logic [BW-1:0]     w_offset;
    logic              w_in_win;
    logic              w_take;

    // Offset test stays valid even for LO == 0 without a constant compare
    assign w_offset = count - c_lo;
    assign w_in_win = (w_offset <= c_span);
    assign w_take   = in_nd && w_in_win && ((count == c_lo) || (in_data > r_max));

    always_ff @(posedge clk) begin
        if (clear) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (w_take) begin
            r_max <= in_data;
            r_idx <= count;
        end
    end

    // Outputs already include this cycle's sample so a window ending at the
    // last bin can be latched on the completion edge.
    assign run_max = w_take ? in_data : r_max;
    assign run_idx = w_take ? count   : r_idx;

endmodule : win_max_tracker
`default_nettype wire

// File: rtl/fft_bin_max.sv
`default_nettype none
// ============================================================================
// Module      : fft_bin_max
// Description : Per-frame maxima of two FFT bin windows with valid/ack output.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bin_max
    import fft_bin_max_pkg::*;
#(
    parameter int DATLEN = c_datlen,
    parameter int NFFT   = c_nfft,
    parameter int BW     = c_bw,
    parameter int LO730  = c_lo730,
    parameter int HI730  = c_hi730,
    parameter int LO850  = c_lo850,
    parameter int HI850  = c_hi850
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              resync,
    input  logic [DATLEN-1:0] in_data,
    input  logic              in_nd,
    input  logic              in_ovf,
    output logic [DATLEN-1:0] max730,
    output logic [DATLEN-1:0] max850,
    output logic [BW-1:0]     bin730,
    output logic [BW-1:0]     bin850,
    output logic              res_ovf,
    output logic              out_valid,
    input  logic              out_ack,
    output logic              frame_lost
);

    generate
        if (BW != $clog2(NFFT) || NFFT != (1 << BW) || NFFT < 8 || NFFT > 1024) begin : g_bad_nfft
            $error("fft_bin_max: NFFT must be a power of two in 8..1024 with BW == log2(NFFT)");
        end
        if (LO730 < 0 || LO730 > HI730 || HI730 > NFFT - 1) begin : g_bad_win730
            $error("fft_bin_max: 730 window bounds invalid");
        end
        if (LO850 < 0 || LO850 > HI850 || HI850 > NFFT - 1) begin : g_bad_win850
            $error("fft_bin_max: 850 window bounds invalid");
        end
    endgenerate

    localparam logic [BW-1:0] c_last = BW'(NFFT - 1);

    logic [BW-1:0]     r_count;
    logic              r_ovf_run;
    logic [DATLEN-1:0] r_max730;
    logic [DATLEN-1:0] r_max850;
    logic [BW-1:0]     r_bin730;
    logic [BW-1:0]     r_bin850;
    logic              r_res_ovf;
    logic              r_valid;
    logic              r_lost;

    logic              w_fire;
    logic              w_last;
    logic              w_clear;
    logic [DATLEN-1:0] w_run730;
    logic [DATLEN-1:0] w_run850;
    logic [BW-1:0]     w_idx730;
    logic [BW-1:0]     w_idx850;

    // resync outranks a coincident sample, which is simply dropped
    assign w_fire  = in_nd && !resync;
    assign w_last  = w_fire && (r_count == c_last);
    assign w_clear = rst || resync;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_count <= '0;
        end else if (w_fire) begin
            r_count <= w_last ? '0 : r_count + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear || w_last) begin
            r_ovf_run <= 1'b0;
        end else if (in_ovf) begin
            r_ovf_run <= 1'b1;
        end
    end

    win_max_tracker #(
        .LO     (LO730),
        .HI     (HI730),
        .DATLEN (DATLEN),
        .BW     (BW)
    ) u_win730 (
        .clk     (clk),
        .clear   (w_clear),
        .count   (r_count),
        .in_data (in_data),
        .in_nd   (w_fire),
        .run_max (w_run730),
        .run_idx (w_idx730)
    );

    win_max_tracker #(
        .LO     (LO850),
        .HI     (HI850),
        .DATLEN (DATLEN),
        .BW     (BW)
    ) u_win850 (
        .clk     (clk),
        .clear   (w_clear),
        .count   (r_count),
        .in_data (in_data),
        .in_nd   (w_fire),
        .run_max (w_run850),
        .run_idx (w_idx850)
    );

    // An ack coinciding with completion frees the slot for the new result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_max730  <= '0;
            r_max850  <= '0;
            r_bin730  <= '0;
            r_bin850  <= '0;
            r_res_ovf <= 1'b0;
            r_valid   <= 1'b0;
            r_lost    <= 1'b0;
        end else if (w_last) begin
            if (!r_valid || out_ack) begin
                r_max730  <= w_run730;
                r_max850  <= w_run850;
                r_bin730  <= w_idx730;
                r_bin850  <= w_idx850;
                r_res_ovf <= r_ovf_run || in_ovf;
                r_valid   <= 1'b1;
            end else begin
                r_lost    <= 1'b1;
            end
        end else if (out_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign max730     = r_max730;
    assign max850     = r_max850;
    assign bin730     = r_bin730;
    assign bin850     = r_bin850;
    assign res_ovf    = r_res_ovf;
    assign out_valid  = r_valid;
    assign frame_lost = r_lost;

endmodule : fft_bin_max
`default_nettype wire

// File: doc/fft_bin_max.md
Name: fft_bin_max

Overview:
- Downstream of the radix-2 DIT FFT in the DSP path; consumes the FFT output stream (one magnitude word per out_nd strobe).
- Counts bins within each NFFT-point frame and tracks the maximum over two bin windows: the 730 nm and 850 nm LED modulation frequencies.
- At frame end, latches both maxima, their bin indices and an overflow flag.
- Presents the latched result to the microcontroller interface under a valid/ack handshake.

Parameters:
- DATLEN, 12, width of FFT output word and of max outputs.
- NFFT, 64, FFT frame length in bins; power of two, 8..1024.
- BW, 6, bin index width; must equal log2(NFFT).
- LO730, 4, first bin of 730 window (inclusive).
- HI730, 6, last bin of 730 window (inclusive).
- LO850, 10, first bin of 850 window (inclusive).
- HI850, 12, last bin of 850 window (inclusive).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- resync  in  1  one-cycle pulse: abandon current frame, bin counter to 0
- in_data  in  DATLEN  FFT output magnitude, unsigned
- in_nd  in  1  in_data valid this cycle (FFT out_nd)
- in_ovf  in  1  FFT overflow indication
- max730  out  DATLEN  latched max over 730 window
- max850  out  DATLEN  latched max over 850 window
- bin730  out  BW  bin index of max730
- bin850  out  BW  bin index of max850
- res_ovf  out  1  overflow seen during the latched frame
- out_valid  out  1  result pending for microcontroller
- out_ack  in  1  microcontroller consumed result
- frame_lost  out  1  sticky: a completed frame was discarded

Behaviour:
- Reset:
  - All outputs 0.
  - Bin counter 0; running maxima and indices 0; running ovf 0.
- Bin counter:
  - Increments on each in_nd; wraps NFFT-1 -> 0.
  - The sample with in_nd at count k is bin k.
- Running max, per window, on in_nd with LO<=k<=HI:
  - At k==LO the running value is loaded unconditionally with in_data and index k.
  - Otherwise the running value is replaced only if in_data > running value (strict; ties keep the lower bin).
  - Compare is unsigned, DATLEN bits; no width growth.
- Running ovf:
  - Set on any cycle in_ovf=1 while a frame is in progress.
  - Cleared when the frame completes or on resync.
- Frame completion:
  - Occurs on the cycle in_nd=1 with k==NFFT-1.
  - The final sample is included in the compare if in window. HI=NFFT-1 is legal: the final sample participates and the loaded value is the post-compare value.
  - On the next edge, if out_valid==0 or out_ack==1: load max730, max850, bin730, bin850, res_ovf; out_valid=1.
  - Latency: 1 cycle from the last in_nd to out_valid.
  - Else (result still pending, no ack): outputs unchanged; frame_lost set.
- Handshake:
  - out_valid holds, with outputs stable, until a cycle with out_ack=1; it clears on the next edge unless a frame completes in that same cycle.
  - Simultaneous ack and completion: the new result loads and out_valid stays 1; nothing is lost.
  - out_ack with out_valid=0 is ignored.
- frame_lost: cleared only by rst.
- resync:
  - Counter to 0; running maxima and ovf cleared; latched outputs and out_valid untouched.
  - resync together with in_nd: resync wins, the sample is dropped, and the next in_nd is bin 0.
- rst mid-frame: partial frame discarded; the first in_nd after rst deasserts is bin 0.
- Windows must not exceed NFFT-1 and must satisfy LO<=HI; check this by elaboration-time assertion. Windows may overlap; each tracks independently.

Decomposition:
- Shared package, also used by the ADC reader and FFT wrapper:
  - DATLEN constant.
  - NFFT and BW constants.
  - Default window bounds.
  - The result record typedef: two maxima, two indices, ovf.
- One sub-module: win_max_tracker.
  - Parameters LO, HI, DATLEN, BW.
  - Inputs: count, in_data, in_nd, clear.
  - Outputs: running max and index.
  - Instantiated twice.
- Counter, completion logic and handshake live in the top.

Test Plan:
- Single frame, NFFT=64, in_data=bin index*10 except bin5=900 and bin11=700 → out_valid 1 cycle after bin 63; max730=900, bin730=5; max850=700, bin850=11; res_ovf=0.
- Ties: bins 4,5,6 all =300 → max730=300, bin730=4. Bin 10=0, bin 12=4095 → max850=4095, bin850=12.
- No ack across two frames → first result held unchanged; frame_lost=1 after second frame end. Ack on the exact completion cycle of a third frame → third result loaded, out_valid stays 1, frame_lost stays 1.
- in_ovf pulse at bin 20 → res_ovf=1 for that frame; next clean frame → res_ovf=0.
- Gaps: in_nd high only every 3rd cycle → identical results to the back-to-back case.
- resync asserted at bin 30, then a fresh full 64-sample frame → results reflect only the fresh frame. rst asserted at bin 40 → all outputs 0, out_valid 0; the next frame completes normally.
